// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests a word from instruction memory, holds it for
// downstream execute, then advances CurrentPC sequentially or by a branch offset.
module instruction_fetch #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startPC,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [25:0] Imm26,
  output logic [1:0]  Ctrl,
  input  logic [63:0] BusImm,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        Zero,
  input  logic        ExDone,
  output logic [63:0] CurrentPC,
  output logic        Timeout
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StError} state_e;

  localparam logic [7:0] MaxWaitW = 8'(MAX_WAIT);

  state_e      state_q;
  logic [63:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        imem_req_q;
  logic        timeout_q;
  logic [7:0]  wait_cnt_q;

  logic [7:0]  wait_cnt_inc;
  logic        taken;
  logic [63:0] pc_seq;
  logic [63:0] pc_br;
  logic [63:0] pc_next;
  logic [1:0]  ctrl;

  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  // PC arithmetic wraps modulo 2^64 by construction.
  assign taken   = Uncondbranch | (Branch & Zero);
  assign pc_seq  = pc_q + 64'd4;
  assign pc_br   = pc_q + (BusImm << 2);
  assign pc_next = taken ? pc_br : pc_seq;

  // Immediate format for the sign extender, highest priority first.
  always_comb begin
    ctrl = 2'b00;
    if (instr_q[31:26] == 6'b000101) begin
      ctrl = 2'b11;
    end else if (instr_q[31:24] == 8'b10110100) begin
      ctrl = 2'b10;
    end else if (instr_q[28:26] == 3'b100) begin
      ctrl = 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q       <= StIdle;
      pc_q          <= startPC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      timeout_q     <= 1'b0;
      wait_cnt_q    <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
          wait_cnt_q <= 8'd0;
        end
        StFetch: begin
          // An ack on the final wait cycle still wins over the timeout.
          if (IMemAck) begin
            instr_q       <= IMemData;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= StIssue;
          end else if (wait_cnt_inc == MaxWaitW) begin
            wait_cnt_q <= wait_cnt_inc;
            imem_req_q <= 1'b0;
            timeout_q  <= 1'b1;
            state_q    <= StError;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
          end
        end
        StIssue: begin
          if (ExDone) begin
            pc_q          <= pc_next;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            wait_cnt_q    <= 8'd0;
            state_q       <= StFetch;
          end
        end
        StError: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          timeout_q     <= 1'b1;
        end
        default: begin
          state_q <= StError;
        end
      endcase
    end
  end

  assign IMemReq     = imem_req_q;
  assign IMemAddr    = pc_q;
  assign InstrValid  = instr_valid_q;
  assign Instruction = instr_q;
  assign Imm26       = instr_q[25:0];
  assign Ctrl        = ctrl;
  assign CurrentPC   = pc_q;
  assign Timeout     = timeout_q;

endmodule
